// File: rtl/alu_ctrl_pkg.sv
// rtl/alu_ctrl_pkg.sv - shared encodings for the ALU issue controller
//
// Purpose: ALU op codes, ALUOp request codes, R-type funct constants and
// the issue FSM state type, shared by the decoder and the controller.
// Ports: none (package).
package alu_ctrl_pkg;

  // ALU operation codes; bit 2 is b-invert / carry-in.
  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  // Request ALUOp codes.
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ILL   = 2'b11;

  // R-type funct fields.
  localparam logic [5:0] FUNCT_ADD  = 6'b100000;
  localparam logic [5:0] FUNCT_ADDU = 6'b100001;
  localparam logic [5:0] FUNCT_SUB  = 6'b100010;
  localparam logic [5:0] FUNCT_SUBU = 6'b100011;
  localparam logic [5:0] FUNCT_AND  = 6'b100100;
  localparam logic [5:0] FUNCT_OR   = 6'b100101;
  localparam logic [5:0] FUNCT_SLT  = 6'b101010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_op_decode.sv
// rtl/alu_op_decode.sv - combinational ALUOp/funct to ALU op decoder
//
// Purpose: map a MIPS-style (aluop, funct) pair onto the ALU op, the
// overflow-trap enable and an illegal flag.
// Ports:
//   aluop   in  2  request ALUOp code
//   funct   in  6  R-type funct, only looked at when aluop is R-type
//   op      out 3  ALU operation
//   trap_en out 1  signed overflow should trap
//   illegal out 1  unsupported aluop/funct
module alu_op_decode
  import alu_ctrl_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] op,
  output logic       trap_en,
  output logic       illegal
);

  always_comb begin
    op      = OP_AND;
    trap_en = 1'b0;
    illegal = 1'b0;
    case (aluop)
      ALUOP_ADD: op = OP_ADD;
      ALUOP_SUB: op = OP_SUB;
      ALUOP_RTYPE: begin
        case (funct)
          FUNCT_ADD:  begin op = OP_ADD; trap_en = 1'b1; end
          FUNCT_ADDU: op = OP_ADD;
          FUNCT_SUB:  begin op = OP_SUB; trap_en = 1'b1; end
          FUNCT_SUBU: op = OP_SUB;
          FUNCT_AND:  op = OP_AND;
          FUNCT_OR:   op = OP_OR;
          FUNCT_SLT:  op = OP_SLT;
          default:    illegal = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - multi-cycle issue controller in front of the ALU
//
// Purpose: accept one op per request handshake, decode it, hold registered
// operands on the ALU for ALU_CYCLES cycles, capture the ALU outputs and
// return them as a response with trap and illegal flags.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   req_valid/req_ready            request handshake
//   req_aluop, req_funct           operation selection
//   req_a, req_b                   operands
//   alu_a, alu_b, alu_op           registered drive to the ALU
//   alu_result, alu_set,
//   alu_zero, alu_overflow         ALU outputs (alu_set not used)
//   rsp_valid/rsp_ready            response handshake
//   rsp_result, rsp_zero,
//   rsp_trap, rsp_illegal          response payload
module alu_issue_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int ALU_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_aluop,
  input  logic [5:0]  req_funct,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_op,
  input  logic [31:0] alu_result,
  input  logic        alu_set,
  input  logic        alu_zero,
  input  logic        alu_overflow,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_zero,
  output logic        rsp_trap,
  output logic        rsp_illegal
);

  localparam logic [3:0] CNT_LOAD = 4'(ALU_CYCLES - 1);

  state_t     state;
  logic [3:0] cnt;
  logic       trap_en;

  logic [2:0] dec_op;
  logic       dec_trap_en;
  logic       dec_illegal;

  // SLT arrives as alu_result[0], so the separate set flag is not needed.
  logic       alu_set_unused;
  assign alu_set_unused = alu_set;

  alu_op_decode u_decode (
    .aluop   (req_aluop),
    .funct   (req_funct),
    .op      (dec_op),
    .trap_en (dec_trap_en),
    .illegal (dec_illegal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      req_ready   <= 1'b1;
      cnt         <= 4'd0;
      trap_en     <= 1'b0;
      alu_a       <= 32'd0;
      alu_b       <= 32'd0;
      alu_op      <= OP_AND;
      rsp_valid   <= 1'b0;
      rsp_result  <= 32'd0;
      rsp_zero    <= 1'b0;
      rsp_trap    <= 1'b0;
      rsp_illegal <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            alu_a     <= req_a;
            alu_b     <= req_b;
            trap_en   <= dec_trap_en;
            if (dec_illegal) begin
              // Skip the ALU entirely; the response is fixed.
              state       <= ST_RESP;
              alu_op      <= OP_AND;
              rsp_result  <= 32'd0;
              rsp_zero    <= 1'b0;
              rsp_trap    <= 1'b0;
              rsp_illegal <= 1'b1;
            end else begin
              state  <= ST_EXEC;
              alu_op <= dec_op;
              cnt    <= CNT_LOAD;
            end
          end
        end
        ST_EXEC: begin
          if (cnt == 4'd0) begin
            state       <= ST_RESP;
            alu_op      <= OP_AND;
            rsp_valid   <= 1'b1;
            rsp_result  <= alu_result;
            rsp_zero    <= alu_zero;
            rsp_trap    <= alu_overflow & trap_en;
            rsp_illegal <= 1'b0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_RESP: begin
          // An illegal request enters here with rsp_valid low and raises it
          // one cycle later, giving it the same turnaround as a one-cycle op.
          if (!rsp_valid) begin
            rsp_valid <= 1'b1;
          end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
          alu_op    <= OP_AND;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Multi-cycle issue controller that sits in front of the 32-bit ALU datapath and drives it from the opposite side of the ALU's `a`/`b`/`op` interface. It accepts one operation per request handshake and decodes MIPS-style ALUOp/funct into the ALU's 3-bit `op`. It presents registered operands, waits a configurable number of cycles, captures `result`/`set`/`zero`/`overflow`, and returns a response with overflow-trap and illegal-funct flags.

## Interface
Parameters:
- `ALU_CYCLES`, default 1: cycles operands are held before capture, legal range 1..15.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  controller can accept a request.
- `req_aluop`  in  2  00 add (lw/sw), 01 sub (beq), 10 decode funct, 11 illegal.
- `req_funct`  in  6  R-type funct field; ignored unless `req_aluop`=10.
- `req_a`, `req_b`  in  32  operands.
- `alu_a`, `alu_b`  out  32  operands to the ALU, driven from registers.
- `alu_op`  out  3  ALU operation; `op[2]` is b-invert/carry-in.
- `alu_result`  in  32  ALU result.
- `alu_set`, `alu_zero`, `alu_overflow`  in  1  ALU flags.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer accepts response.
- `rsp_result`  out  32  captured result.
- `rsp_zero`  out  1  captured zero flag.
- `rsp_trap`  out  1  signed overflow on a trapping op.
- `rsp_illegal`  out  1  unsupported aluop/funct.

## Operation
- Op encodings: AND=000, OR=001, ADD=010, SUB=110, SLT=111.
- Decode for `req_aluop`=10, funct to op and trap-enable:
  - 100000 → ADD, trap on.
  - 100001 → ADD, trap off.
  - 100010 → SUB, trap on.
  - 100011 → SUB, trap off.
  - 100100 → AND.
  - 100101 → OR.
  - 101010 → SLT.
  - Any other funct is illegal.
- `req_aluop`=00 → ADD, no trap. 01 → SUB, no trap. 11 → illegal.
- FSM states:
  - IDLE: `req_ready`=1. On `req_valid`, register operands, op and trap-enable. Go to EXEC if the op is legal; go to RESP with illegal set if not.
  - EXEC: `alu_op` holds the decoded op. A down-counter loads `ALU_CYCLES-1` on entry. When the counter is 0, capture `alu_result`, `alu_zero`, and `alu_overflow & trap_en`, then go to RESP.
  - RESP: `rsp_valid`=1 with stable data. On `rsp_ready`, go to IDLE.
- Illegal request: `rsp_result`=0, `rsp_zero`=0, `rsp_trap`=0, `rsp_illegal`=1. No EXEC cycle is spent.
- On a trap, `rsp_result` still carries the wrapped 32-bit sum/difference.
- `alu_op`=000 whenever the FSM is not in EXEC. `alu_a`/`alu_b` hold their last registered values.
- `alu_set` is not consumed; SLT's result already arrives in `alu_result[0]`.

## Timing
- Reset: state IDLE.
  - `req_ready`=1 on the first cycle after reset deasserts.
  - All other outputs, operand registers and the counter are 0.
- `req_ready` is asserted only in IDLE, so there is no accept/response overlap.
- Legal request accepted at edge N:
  - EXEC covers cycles N..N+ALU_CYCLES-1.
  - `rsp_valid` rises after edge N+ALU_CYCLES.
- Illegal request accepted at edge N: `rsp_valid` rises after edge N+1.
- `rsp_valid` deasserts the cycle after the `rsp_valid & rsp_ready` edge, and `req_ready` rises in the same cycle.
- Minimum issue interval is ALU_CYCLES+2 cycles when `rsp_ready` is held high.
- Back-pressure: RESP holds indefinitely. `rsp_*` must not change while `rsp_valid`=1 and `rsp_ready`=0.
- `rst` at any edge, including mid-EXEC or in RESP, returns the FSM to IDLE. The in-flight operation is dropped with no response.

## Structure
- Package `alu_ctrl_pkg` holds:
  - op encodings (AND/OR/ADD/SUB/SLT),
  - `req_aluop` codes,
  - funct constants,
  - the FSM state enum (IDLE/EXEC/RESP).
- Sub-module `alu_op_decode` is purely combinational: (aluop, funct) → (op[2:0], trap_en, illegal). It is reusable by the main control unit.
- Top-level `alu_issue_ctrl` contains the FSM, counter, operand/op registers and response registers.
- The ALU is external; benches instantiate the existing 32-bit ALU behind `alu_*`.

## Test plan
- R-type add, funct 100000, a=7, b=5, ALU_CYCLES=1:
  - `alu_op`=010 during EXEC.
  - `rsp_valid` at N+1 with `rsp_result`=12, `rsp_zero`=0, `rsp_trap`=0.
- Trap versus no trap on overflow, a=0x7FFFFFFF, b=1:
  - funct 100000 → `rsp_result`=0x80000000, `rsp_trap`=1.
  - funct 100001 → same result, `rsp_trap`=0.
- beq path, `req_aluop`=01, a=b=0x1234:
  - `alu_op`=110.
  - `rsp_result`=0, `rsp_zero`=1.
- SLT, a=0xFFFFFFFF (−1), b=1:
  - `rsp_result`=1.
  - With a and b swapped, `rsp_result`=0.
- Illegal funct 000000:
  - `rsp_illegal`=1, `rsp_result`=0.
  - `rsp_valid` one cycle after accept.
  - `alu_op` stays 000 throughout.
- Back-pressure and reset, ALU_CYCLES=3:
  - Hold `rsp_ready`=0 for 5 cycles; `rsp_*` stay stable and `req_ready` stays 0.
  - A second run asserts `rst` in the second EXEC cycle: next cycle is IDLE, `req_ready`=1, no `rsp_valid` ever asserted.
